accel_scheduler: RTL
====================

# accel_scheduler

Round-robin scheduler that shares the single 8-element signed dot-product `accelerator` between `NREQ` requesters. It accepts one job at a time over a valid/ready handshake and latches the operand vectors. It pulses the accelerator `start`, waits for `done` with a watchdog, and returns the 64-bit result (or an error) to the requester that issued the job. It sits between the SoC bus-side requesters and the `accelerator` instance.

## Interface
- `NREQ`, 2, number of requesters (2..4)
- `N`, 8, vector length; must match the accelerator
- `W`, 32, signed element width
- `TIMEOUT`, 255, maximum WAIT cycles before the job is aborted (1..65535)

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, **asynchronous, active-high**
- `req_valid` in NREQ: job request per requester
- `req_ready` out NREQ: job accepted (one-hot or zero)
- `req_a`, `req_b` in NREQ×N×W signed: operand vectors per requester
- `resp_valid` out NREQ: response valid, one-hot to the granted requester
- `resp_ready` in NREQ: response consumed
- `resp_result` out 2W signed: dot-product result, shared by all requesters
- `resp_error` out 1: 1 = watchdog timeout, result forced to 0
- `accel_start` out 1: one-cycle start pulse to the accelerator
- `accel_a`, `accel_b` out N×W signed: registered operands to the accelerator
- `accel_done` in 1: accelerator completion
- `accel_result` in 2W signed: accelerator result
- `busy` out 1: state ≠ IDLE
- `grant_id` out clog2(NREQ): requester owning the current job

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Winner = first requester with `req_valid`=1, searching from `last_grant`+1 modulo NREQ.
  - `req_ready[winner]` = 1 combinationally. No other `req_ready` bit is asserted.
  - On the edge with valid&ready: latch `req_a`/`req_b` of the winner into `accel_a`/`accel_b`, latch `grant_id`, go to ISSUE.
- **ISSUE**: `accel_start`=1 for this cycle only. Clear the watchdog counter. Go to WAIT.
- **WAIT**: increment the counter each cycle.
  - If `accel_done`=1: latch `accel_result` into `resp_result`, set `resp_error`=0, go to RESP.
  - Else if the counter equals TIMEOUT: set `resp_result`=0, `resp_error`=1, go to RESP.
- **RESP**
  - `resp_valid[grant_id]`=1.
  - `resp_result`, `resp_error` and `grant_id` are held stable.
  - When `resp_ready[grant_id]`=1: set `last_grant`=`grant_id`, go to IDLE.
- `accel_done` is ignored outside WAIT.
- `accel_a`/`accel_b` are held unchanged from acceptance until the next acceptance.
- `req_a`/`req_b` may change freely after the acceptance edge.
- No arithmetic is performed in this block. `resp_result` is a bit-exact copy of the accelerator output.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`, `resp_valid`, `resp_error`, `accel_start`, `busy`, `grant_id`, `resp_result`, `accel_a`, `accel_b` all 0.
  - `last_grant`=NREQ-1, so requester 0 has first priority.
- Acceptance at edge k:
  - `accel_start`=1 during cycle k+1.
  - WAIT entered at edge k+2.
- `accel_done` sampled at edge m → `resp_valid` high from cycle m+1.
- Minimum request-to-response latency is 3 cycles plus accelerator latency.
- Timeout: `resp_valid` rises TIMEOUT+1 cycles after WAIT entry.
- `accel_done` and timeout in the same cycle: done wins.
- Response handshake at edge r → IDLE at r+1. The next acceptance is possible in cycle r+1, giving a 1-cycle bubble between jobs.
- `req_valid` dropped before acceptance: no job is started and no state change occurs.
- `rst` asserted in any state: immediately return to IDLE with reset values.
  - The in-flight job is lost and no response is issued.
  - The accelerator must be reset from the same `rst`.
- `resp_ready` held low: remain in RESP indefinitely with no new acceptance.

## Test plan
- Requester 0 sends a=[1,2,3,4,5,6,7,8], b=[10,10,10,10,1,1,1,1] → `accel_start` pulses once, `resp_valid[0]`=1, `resp_result`=126, `resp_error`=0.
- Requester 1 sends a=[10,-5,100,-1,0,20,-2,1], b=[2,10,-1,20,50,-5,4,-8] → `resp_valid[1]`=1, `resp_result`=-266; `req_ready[0]` stays 0 throughout.
- Both requesters hold `req_valid` continuously for 4 jobs → grant order 0,1,0,1; b=all zeros → every result is 0.
- Accelerator stub never asserts done, TIMEOUT=20 → `resp_error`=1, `resp_result`=0, `resp_valid` rises 21 cycles after WAIT entry; the next job then completes normally.
- `resp_ready` held low for 10 cycles after `resp_valid` → result held stable, `req_ready` stays 0, `busy`=1; release → IDLE next cycle.
- `rst` pulsed mid-WAIT → all outputs return to 0 asynchronously and no `resp_valid` is issued. The next request from requester 0 is granted first and returns the correct result.

Source files
------------

// File: rtl/accel_scheduler_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces around accel_scheduler.
//
// accel_scheduler_if : requester side (job request + response), one lane per
//                      requester for the request, shared result/error lines.
//   master modport  - requesters: drive req_valid/req_a/req_b/resp_ready,
//                     observe req_ready/resp_valid/resp_result/resp_error.
//   slave modport   - scheduler: the mirror image.
//
// accel_port_if      : scheduler <-> dot-product accelerator.
//   master modport  - scheduler: drives accel_start/accel_a/accel_b,
//                     observes accel_done/accel_result.
//   slave modport   - accelerator: the mirror image.
// -----------------------------------------------------------------------------
interface accel_scheduler_if #(
  parameter int NREQ = 2,
  parameter int N    = 8,
  parameter int W    = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic signed [W-1:0]   req_a [NREQ][N];
  logic signed [W-1:0]   req_b [NREQ][N];
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic signed [2*W-1:0] resp_result;
  logic                  resp_error;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_error
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_error
  );
endinterface

interface accel_port_if #(
  parameter int N = 8,
  parameter int W = 32
);
  logic                  accel_start;
  logic signed [W-1:0]   accel_a [N];
  logic signed [W-1:0]   accel_b [N];
  logic                  accel_done;
  logic signed [2*W-1:0] accel_result;

  modport master (
    output accel_start, accel_a, accel_b,
    input  accel_done, accel_result
  );

  modport slave (
    input  accel_start, accel_a, accel_b,
    output accel_done, accel_result
  );
endinterface

// File: rtl/accel_scheduler.sv
// -----------------------------------------------------------------------------
// accel_scheduler
//
// Round-robin arbiter that lends a single dot-product accelerator to NREQ
// requesters, one job at a time. A job is accepted on a valid/ready
// handshake, its operand vectors are registered towards the accelerator, a
// one-cycle start pulse is issued, and completion is awaited under a
// watchdog. The result (or a timeout error with a zero result) is handed
// back to the requester that owns the job.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - asynchronous, active-high reset (also resets the accelerator)
//   req_if      - requester bus (slave side): request/response handshakes,
//                 operand vectors, shared result and error
//   acc_if      - accelerator port (master side): start, operands, done, result
//   busy_o      - high whenever a job is in flight (state other than IDLE)
//   grant_id_o  - requester owning the current/last job
// -----------------------------------------------------------------------------
module accel_scheduler #(
  parameter int NREQ    = 2,
  parameter int N       = 8,
  parameter int W       = 32,
  parameter int TIMEOUT = 255,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  accel_scheduler_if.slave req_if,
  accel_port_if.master     acc_if,
  output logic             busy_o,
  output logic [IDW-1:0]   grant_id_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // 16 bits covers the full TIMEOUT range; the count never passes TIMEOUT.
  localparam int             CW        = 16;
  localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_RST  = IDW'(NREQ - 1);

  state_e                state_q;
  logic [IDW-1:0]        grant_q;
  logic [IDW-1:0]        last_q;
  logic [CW-1:0]         wdog_q;
  logic                  start_q;
  logic                  busy_q;
  logic                  err_q;
  logic [NREQ-1:0]       resp_valid_q;
  logic signed [2*W-1:0] result_q;
  logic signed [W-1:0]   a_q [N];
  logic signed [W-1:0]   b_q [N];

  logic                  win_vld_d;
  logic [IDW-1:0]        win_id_d;
  logic [IDW-1:0]        idx_d;
  logic [NREQ-1:0]       ready_d;

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // Round-robin winner: first valid requester after last_q, wrapping around.
  always_comb begin
    win_vld_d = 1'b0;
    win_id_d  = '0;
    idx_d     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx_d     = IDW'((int'(last_q) + i) % NREQ);
      win_id_d  = (!win_vld_d && req_if.req_valid[idx_d]) ? idx_d : win_id_d;
      win_vld_d = win_vld_d | req_if.req_valid[idx_d];
    end
  end

  // Ready is combinational, offered only to the winner and only while idle.
  always_comb begin
    ready_d = '0;
    if (state_q == S_IDLE && win_vld_d) begin
      ready_d = onehot(win_id_d);
    end else begin
      ready_d = '0;
    end
  end

  // Drive the accelerator operands from their holding registers.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_if.accel_a[i] = a_q[i];
      acc_if.accel_b[i] = b_q[i];
    end
  end

  assign req_if.req_ready   = ready_d;
  assign req_if.resp_valid  = resp_valid_q;
  assign req_if.resp_result = result_q;
  assign req_if.resp_error  = err_q;
  assign acc_if.accel_start = start_q;
  assign busy_o             = busy_q;
  assign grant_id_o         = grant_q;

  // Job FSM with all its outputs held in registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_q       <= LAST_RST;
      wdog_q       <= '0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
      result_q     <= '0;
      for (int i = 0; i < N; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Winner's ready is up, so a valid winner means the handshake fires.
          if (win_vld_d) begin
            for (int i = 0; i < N; i++) begin
              a_q[i] <= req_if.req_a[win_id_d][i];
              b_q[i] <= req_if.req_b[win_id_d][i];
            end
            grant_q <= win_id_d;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          wdog_q <= wdog_q + 16'd1;
          // Completion has priority over a watchdog expiry in the same cycle.
          if (acc_if.accel_done) begin
            result_q     <= acc_if.accel_result;
            err_q        <= 1'b0;
            resp_valid_q <= onehot(grant_q);
            state_q      <= S_RESP;
          end else if (wdog_q == TIMEOUT_C) begin
            result_q     <= '0;
            err_q        <= 1'b1;
            resp_valid_q <= onehot(grant_q);
            state_q      <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_RESP: begin
          if (req_if.resp_ready[grant_q]) begin
            last_q       <= grant_q;
            resp_valid_q <= '0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
